sig_avg_sched: RTL and testbench
================================

Name: sig_avg_sched

Overview:
Shares one block-averaging accumulator datapath among NCH electrode channels. Each channel presents samples over a valid/ready handshake. A round-robin arbiter grants one sample per cycle into that channel's running sum. After AVG_N samples, the block emits floor(sum/AVG_N) tagged with the channel index through a 1-deep output buffer, and sits between the ADC front-end and the downstream feature/transmit logic.

Parameters:
NCH, 4, number of channels (2..16)
DATLEN, 12, unsigned sample/average width in bits
AVG_N_LOG2, 6, log2 of samples per average (AVG_N = 64)
CH_W, 2, channel-index width, equal to clog2(NCH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  NCH  per-channel sample valid
in_data  in  NCH*DATLEN  channel i occupies bits [i*DATLEN +: DATLEN]
in_ready  out  NCH  per-channel accept; one-hot or zero
clear  in  1  pulse: discard all partial sums and counts
out_valid  out  1  average available
out_ready  in  1  downstream accept
out_chan  out  CH_W  channel index of out_avg
out_avg  out  DATLEN  block average
busy  out  1  high while in CLEAR state

Behaviour:
- Reset (rst_n low, async): state=CLEAR, clr_idx=0, rr_ptr=0, all sums/counts=0, out_valid=0, out_chan=0, out_avg=0, in_ready=0, busy=1. Clock and reset use exactly one clock; reset is asynchronous and active-low.
- Storage per channel: sum[i] is DATLEN+AVG_N_LOG2 bits. cnt[i] is AVG_N_LOG2 bits. Sums cannot overflow: max 64*4095 = 262080 < 2^18.
- FSM states: CLEAR, RUN.
  - CLEAR zeroes sum/cnt of channel clr_idx each cycle. After clr_idx = NCH-1 it goes to RUN, with clr_idx=0. Takes NCH cycles. in_ready=0 and busy=1 throughout.
  - RUN goes to CLEAR on a clear pulse. That cycle's grant is suppressed, so no sample is accepted.
  - CLEAR restarts at index 0 if clear is reasserted while in CLEAR.
- Output buffer contents are unaffected by clear. A pending out_valid holds until its handshake.
- Arbitration in RUN:
  - Eligible(i) = in_valid[i] && !(cnt[i]==AVG_N-1 && out_valid && !out_ready).
  - Grant goes to the first eligible channel searching from rr_ptr upward with wrap.
  - in_ready = one-hot grant, combinational from in_valid/state/counters/out handshake.
  - On a grant to channel g, rr_ptr <= g+1 mod NCH. rr_ptr is unchanged if there is no grant.
- Accept (in_valid[g] && in_ready[g]):
  - If cnt[g] < AVG_N-1: sum[g] += sample, cnt[g]++.
  - If cnt[g] == AVG_N-1 (completing sample): out_avg <= (sum[g]+sample) >> AVG_N_LOG2 (truncating floor), out_chan <= g, out_valid <= 1, sum[g] <= 0, cnt[g] <= 0.
  - Latency: completing sample accepted at edge t gives out_valid high after edge t.
- Output handshake:
  - out_valid/out_chan/out_avg are stable while out_valid && !out_ready.
  - out_valid clears after out_valid && out_ready unless a new completion loads in the same cycle.
  - Simultaneous drain and load gives back-to-back averages with no bubble.
- Boundary cases:
  - Only completing samples stall on a full output buffer. Non-completing samples of the same or other channels keep flowing.
  - in_valid deasserted mid-block leaves the partial sum held indefinitely.
  - rst_n asserted mid-block discards everything asynchronously. After release, in_ready stays 0 for NCH cycles.

Test Plan:
1. Reset release, all in_valid=1: in_ready=0 and busy=1 for 4 cycles; then in_ready cycles 0001, 0010, 0100, 1000, 0001…
2. Channel 2 only, 64 samples of 100 with out_ready=1: out_valid pulses 1 cycle after the 64th accept, with out_chan=2, out_avg=100. No other output.
3. Channel 0 sends 63×4095 then 1×0: out_avg=4031 (floor of 257985/64). Channel 1 sends 64×4095: out_avg=4095.
4. out_ready=0. Channel 0 completes (avg 10); channel 1 is at cnt=63 with in_valid=1; channel 3 is mid-block.
   - in_ready[1] stays 0 while channel 3 is still granted.
   - Raising out_ready for one cycle lets channel 1 complete on that same cycle: output goes avg 10 then channel 1's average with no bubble.
5. Channel 0 has 40 samples of 50. Pulse clear, wait 4 cycles, then send 64 samples of 8: out_avg=8, proving the partial sum was discarded. A pending out_valid across the clear is delivered unchanged.
6. Drop rst_n asynchronously mid-cycle with out_valid=1: out_valid, in_ready and out_avg go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sig_avg_sched.sv
`default_nettype none
// ============================================================================
//  Module   : sig_avg_sched
//  Purpose  : Shares one block-averaging accumulator among NCH channels.
//             A round-robin arbiter admits one sample per cycle into the
//             granted channel's running sum. Every AVG_N samples the channel
//             emits floor(sum/AVG_N) with its index through a 1-deep buffer.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             in_valid   - per-channel sample valid        [NCH]
//             in_data    - channel i at [i*DATLEN +: DATLEN]
//             in_ready   - one-hot (or zero) per-channel accept
//             clear      - pulse: discard all partial sums and counts
//             out_valid  - average available
//             out_ready  - downstream accept
//             out_chan   - channel index of out_avg
//             out_avg    - block average
//             busy       - high while clearing channel storage
//  Revision : 1.0 - initial release
// ============================================================================
module sig_avg_sched #(
    parameter int NCH        = 4,
    parameter int DATLEN     = 12,
    parameter int AVG_N_LOG2 = 6,
    parameter int CH_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          in_valid,
    input  logic [NCH*DATLEN-1:0]   in_data,
    output logic [NCH-1:0]          in_ready,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_chan,
    output logic [DATLEN-1:0]       out_avg,
    output logic                    busy
);

    localparam int                    c_sum_w    = DATLEN + AVG_N_LOG2;
    localparam logic [0:0]            c_st_clear = 1'b0;
    localparam logic [0:0]            c_st_run   = 1'b1;
    localparam logic [CH_W-1:0]       c_last_ch  = CH_W'(NCH - 1);
    localparam logic [AVG_N_LOG2-1:0] c_cnt_last = '1;

    logic [0:0]            state_q, state_d;
    logic [CH_W-1:0]       clr_idx_q, clr_idx_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [c_sum_w-1:0]    sum_q [NCH];
    logic [AVG_N_LOG2-1:0] cnt_q [NCH];
    logic                  out_valid_q;
    logic [CH_W-1:0]       out_chan_q;
    logic [DATLEN-1:0]     out_avg_q;

    logic [NCH-1:0]        w_elig;
    logic                  w_grant_any;
    logic [CH_W-1:0]       w_grant_idx;
    logic [CH_W-1:0]       w_cand;
    logic                  w_accept;
    logic                  w_complete;
    logic [DATLEN-1:0]     w_sample;
    logic [c_sum_w-1:0]    w_sum_next;

    // A channel about to complete must not be admitted while the output
    // buffer is full and not draining this cycle; all other samples flow.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_elig[i] = in_valid[i] &&
                        !((cnt_q[i] == c_cnt_last) && out_valid_q && !out_ready);
        end
    end

    // First eligible channel searching upward from rr_ptr with wrap.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = 0; k < NCH; k++) begin
            w_cand = CH_W'((int'(rr_ptr_q) + k) % NCH);
            if (!w_grant_any && w_elig[w_cand]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // A clear pulse in RUN suppresses that cycle's grant.
    assign w_accept   = (state_q == c_st_run) && !clear && w_grant_any;
    assign w_sample   = in_data[w_grant_idx*DATLEN +: DATLEN];
    assign w_sum_next = sum_q[w_grant_idx] + c_sum_w'(w_sample);
    assign w_complete = w_accept && (cnt_q[w_grant_idx] == c_cnt_last);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= c_st_clear;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            c_st_clear: begin
                if (clear) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == c_last_ch) begin
                    state_d   = c_st_run;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            c_st_run: begin
                if (clear) begin
                    state_d   = c_st_clear;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = c_st_clear;
                clr_idx_d = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = '0;
        if (w_accept) begin
            in_ready[w_grant_idx] = 1'b1;
        end
        busy = (state_q == c_st_clear);
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_accept) begin
            rr_ptr_d = (w_grant_idx == c_last_ch) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // Accumulators and output buffer. The buffer is deliberately untouched
    // by the clearing sweep so a pending average survives a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_avg_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (state_q == c_st_clear) begin
                sum_q[clr_idx_q] <= '0;
                cnt_q[clr_idx_q] <= '0;
            end else if (w_accept) begin
                if (w_complete) begin
                    sum_q[w_grant_idx] <= '0;
                    cnt_q[w_grant_idx] <= '0;
                end else begin
                    sum_q[w_grant_idx] <= w_sum_next;
                    cnt_q[w_grant_idx] <= cnt_q[w_grant_idx] + 1'b1;
                end
            end
            // Load takes priority so drain+load yields back-to-back averages.
            if (w_complete) begin
                out_valid_q <= 1'b1;
                out_chan_q  <= w_grant_idx;
                out_avg_q   <= w_sum_next[c_sum_w-1:AVG_N_LOG2];
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_avg   = out_avg_q;

endmodule
`default_nettype wire

// File: tb/tb_sig_avg_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sig_avg_sched
//  Purpose  : Directed self-checking bench for sig_avg_sched (NCH=4,
//             DATLEN=12, AVG_N=64). Inputs change on the falling edge and
//             outputs are compared away from the rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sig_avg_sched;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        clear     = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  in_valid  = '0;
    logic [47:0] in_data   = '0;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [1:0]  out_chan;
    logic [11:0] out_avg;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int bad;
    logic [3:0] rr_exp [5];

    sig_avg_sched #(
        .NCH        (4),
        .DATLEN     (12),
        .AVG_N_LOG2 (6),
        .CH_W       (2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_avg   (out_avg),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive one channel alone for n cycles; being the only requester it is
    // granted on every rising edge.
    task automatic feed(input int ch, input logic [11:0] d, input int n);
        in_data[ch*12 +: 12] = d;
        in_valid[ch]         = 1'b1;
        repeat (n) step();
        in_valid[ch]         = 1'b0;
    endtask

    task automatic do_clear();
        in_valid = '0;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // ---- 1: reset values, clearing sweep, round-robin rotation
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_busy",      busy,      1);
        chk("rst_out_avg",   out_avg,   0);
        chk("rst_out_chan",  out_chan,  0);
        in_valid = 4'hF;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_busy_clear",  busy,     1);
            chk("t1_ready_clear", in_ready, 0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t1_rr_grant", in_ready, rr_exp[i]);
            step();
        end
        do_clear();

        // ---- 2: channel 2 alone, 64 x 100
        out_ready = 1'b1;
        in_data[2*12 +: 12] = 12'd100;
        in_valid = 4'b0100;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (in_ready !== 4'b0100 || out_valid !== 1'b0) bad++;
            step();
        end
        in_valid = '0;
        #1;
        chk("t2_flow_errors", bad,       0);
        chk("t2_out_valid",   out_valid, 1);
        chk("t2_out_chan",    out_chan,  2);
        chk("t2_out_avg",     out_avg,   100);
        step();
        chk("t2_valid_drop",  out_valid, 0);

        // ---- 3: truncating floor and full-scale
        feed(0, 12'd4095, 63);
        feed(0, 12'd0, 1);
        #1;
        chk("t3_valid_a", out_valid, 1);
        chk("t3_chan_a",  out_chan,  0);
        chk("t3_avg_a",   out_avg,   4031);
        step();
        feed(1, 12'd4095, 64);
        #1;
        chk("t3_chan_b",  out_chan,  1);
        chk("t3_avg_b",   out_avg,   4095);
        step();

        // ---- 4: stall of a completing sample, no-bubble drain+load
        feed(1, 12'd20, 63);
        feed(3, 12'd7, 10);
        out_ready = 1'b0;
        feed(0, 12'd10, 64);
        #1;
        chk("t4_valid_a", out_valid, 1);
        chk("t4_avg_a",   out_avg,   10);
        chk("t4_chan_a",  out_chan,  0);
        in_valid = 4'b1010;
        #1;
        chk("t4_ready_ch3",   in_ready, 4'b1000);
        step();
        #1;
        chk("t4_ready_ch3_b", in_ready, 4'b1000);
        chk("t4_hold_valid",  out_valid, 1);
        chk("t4_hold_avg",    out_avg,   10);
        chk("t4_hold_chan",   out_chan,  0);
        out_ready = 1'b1;
        #1;
        chk("t4_ready_ch1",   in_ready, 4'b0010);
        step();
        out_ready = 1'b0;
        in_valid  = '0;
        #1;
        chk("t4_b2b_valid", out_valid, 1);
        chk("t4_b2b_chan",  out_chan,  1);
        chk("t4_b2b_avg",   out_avg,   20);
        out_ready = 1'b1;
        step();
        chk("t4_drained",   out_valid, 0);

        // ---- 5: clear discards partials, pending output survives
        do_clear();
        out_ready = 1'b0;
        feed(2, 12'd5, 64);
        feed(0, 12'd50, 40);
        #1;
        chk("t5_pending_valid", out_valid, 1);
        in_data[0 +: 12] = 12'd8;
        in_valid = 4'b0001;
        clear    = 1'b1;
        #1;
        chk("t5_clear_suppress", in_ready, 0);
        step();
        clear = 1'b0;
        #1;
        chk("t5_busy_a",  busy,     1);
        chk("t5_ready_a", in_ready, 0);
        repeat (3) step();
        #1;
        chk("t5_busy_b",  busy,     1);
        chk("t5_ready_b", in_ready, 0);
        in_valid = '0;
        step();
        chk("t5_run_busy",   busy,      0);
        chk("t5_keep_valid", out_valid, 1);
        chk("t5_keep_avg",   out_avg,   5);
        chk("t5_keep_chan",  out_chan,  2);
        out_ready = 1'b1;
        step();
        chk("t5_drained", out_valid, 0);
        out_ready = 1'b0;
        feed(0, 12'd8, 64);
        #1;
        chk("t5_valid", out_valid, 1);
        chk("t5_avg",   out_avg,   8);
        chk("t5_chan",  out_chan,  0);

        // ---- 6: asynchronous reset mid-cycle
        in_valid = 4'hF;
        #1;
        chk("t6_ready_before", in_ready, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_ready", in_ready,  0);
        chk("t6_async_avg",   out_avg,   0);
        chk("t6_async_busy",  busy,      1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t6_ready_hold", in_ready, 0);
            step();
        end
        #1;
        chk("t6_first_grant", in_ready, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
